// File: rtl/change_dispense_ctrl_pkg.sv
// rtl/change_dispense_ctrl_pkg.sv - shared state codes, denominations and helpers for the change dispenser
package change_dispense_ctrl_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] sel_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CALC   = 3'd1;
  localparam state_t S_SELECT = 3'd2;
  localparam state_t S_REQ    = 3'd3;
  localparam state_t S_REL    = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_FAULT  = 3'd6;

  localparam int N_DEN = 3;

  localparam int unsigned DEN0 = 1;
  localparam int unsigned DEN1 = 2;
  localparam int unsigned DEN2 = 4;

  localparam sel_t SEL_DEN0 = 2'd0;
  localparam sel_t SEL_DEN1 = 2'd1;
  localparam sel_t SEL_DEN2 = 2'd2;

  // Coin value in units for an ejector channel index.
  function automatic int unsigned denom(input sel_t sel);
    case (sel)
      SEL_DEN2: return DEN2;
      SEL_DEN1: return DEN1;
      default:  return DEN0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_coin_stock.sv
// rtl/change_dispense_ctrl_coin_stock.sv - per-denomination coin stock counters with refill and decrement
module change_dispense_ctrl_coin_stock
  import change_dispense_ctrl_pkg::*;
#(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill,
  input  logic             dec,
  input  sel_t             dec_sel,
  output logic [N_DEN-1:0] avail
);

  logic [STOCK_W-1:0] stock [N_DEN];

  // A decrement of an empty counter is dropped so stock can never wrap.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DEN; i++) begin
      if (rst || refill) begin
        stock[i] <= STOCK_W'(STOCK_INIT);
      end else if (dec && (dec_sel == sel_t'(i)) && (stock[i] != '0)) begin
        stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < N_DEN; i++) begin
      avail[i] = (stock[i] != '0);
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - greedy coin dispenser sequencing a four-phase ejector handshake
module change_dispense_ctrl
  import change_dispense_ctrl_pkg::*;
#(
  parameter int VAL_W       = 4,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [VAL_W-1:0] val_tot,
  input  logic [VAL_W-1:0] val_product,
  input  logic             refill,
  input  logic             eject_ack,
  output logic             eject_req,
  output logic [1:0]       eject_sel,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [VAL_W-1:0] remaining
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  state_t             next_state;
  logic               mode_q;
  logic [VAL_W-1:0]   tot_q;
  logic [VAL_W-1:0]   price_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_hit;
  logic [N_DEN-1:0]   avail;
  logic               found;
  sel_t               pick_sel;
  logic               stock_refill;
  logic               stock_dec;

  assign stock_refill = (state == S_IDLE) && refill && !start;
  assign stock_dec    = (state == S_REQ) && eject_ack;

  change_dispense_ctrl_coin_stock #(
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_coin_stock (
    .clk     (clk),
    .rst     (rst),
    .refill  (stock_refill),
    .dec     (stock_dec),
    .dec_sel (eject_sel),
    .avail   (avail)
  );

  // Later checks override earlier ones, so the largest usable coin wins.
  always_comb begin
    found    = 1'b0;
    pick_sel = SEL_DEN0;
    if (avail[SEL_DEN0] && (remaining >= VAL_W'(denom(SEL_DEN0)))) begin
      found    = 1'b1;
      pick_sel = SEL_DEN0;
    end
    if (avail[SEL_DEN1] && (remaining >= VAL_W'(denom(SEL_DEN1)))) begin
      found    = 1'b1;
      pick_sel = SEL_DEN1;
    end
    if (avail[SEL_DEN2] && (remaining >= VAL_W'(denom(SEL_DEN2)))) begin
      found    = 1'b1;
      pick_sel = SEL_DEN2;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_CALC;
      end
      S_CALC: begin
        if (!mode_q && (tot_q < price_q)) next_state = S_FAULT;
        else                               next_state = S_SELECT;
      end
      S_SELECT: begin
        if (remaining == '0) next_state = S_DONE;
        else if (found)      next_state = S_REQ;
        else                 next_state = S_FAULT;
      end
      S_REQ: begin
        if (eject_ack)    next_state = S_REL;
        else if (tmo_hit) next_state = S_FAULT;
      end
      S_REL: begin
        if (!eject_ack)   next_state = S_SELECT;
        else if (tmo_hit) next_state = S_FAULT;
      end
      S_DONE:  next_state = S_IDLE;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      tot_q     <= '0;
      price_q   <= '0;
      remaining <= '0;
      eject_sel <= SEL_DEN0;
      tmo_cnt   <= '0;
    end else begin
      state <= next_state;

      // One counter serves both handshake phases; each new state restarts it.
      if (next_state != state) begin
        tmo_cnt <= '0;
      end else if ((state == S_REQ) || (state == S_REL)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            tot_q   <= val_tot;
            price_q <= val_product;
          end
        end
        S_CALC: begin
          if (mode_q)                  remaining <= tot_q;
          else if (tot_q >= price_q)   remaining <= tot_q - price_q;
        end
        S_SELECT: begin
          if ((remaining != '0) && found) eject_sel <= pick_sel;
        end
        S_REQ: begin
          if (eject_ack) remaining <= remaining - VAL_W'(denom(eject_sel));
        end
        default: ;
      endcase
    end
  end

  assign eject_req = (state == S_REQ);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fault     = (state == S_FAULT);

endmodule
